// File: rtl/gpio_pulpino_pkg.sv
// rtl/gpio_pulpino_pkg.sv - shared field positions, state encodings and turn helper for the GPIO endpoint
`timescale 1ns/1ps
package gpio_pulpino_pkg;

    localparam int DATA_LSB        = 0;
    localparam int IN_TURN_LSB     = 8;
    localparam int OUT_TURN_LSB    = 10;
    localparam int OUT_IO_TURN_BIT = 10;
    localparam int WAIT_BIT        = 11;
    localparam int BYTES_PER_WORD  = 4;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_CAPTURE,
        RX_ACK,
        RX_HOLD
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_ADVANCE,
        TX_WAIT_ACK
    } tx_state_e;

    // Turns are 2-bit counters; 3 -> 0 is an ordinary step.
    function automatic logic [1:0] turn_next(input logic [1:0] t);
        return t + 2'd1;
    endfunction

endpackage

// File: rtl/gpio_sync_bus.sv
// rtl/gpio_sync_bus.sv - N-stage flop synchroniser applied to a whole bus so its bits stay coherent
`timescale 1ns/1ps
module gpio_sync_bus #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk & resetn;
            assign q = d;
        end else begin : g_sync
            logic [WIDTH-1:0] stage_q [STAGES];

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= d;
                    for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q = stage_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/gpio_pulpino_endpoint.sv
// rtl/gpio_pulpino_endpoint.sv - Pulpino-side GPIO byte-handshake endpoint: RX word reassembly and TX word serialisation
`timescale 1ns/1ps
module gpio_pulpino_endpoint
    import gpio_pulpino_pkg::*;
#(
    parameter int pSYNC_STAGES = 2,
    parameter int pACK_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic [31:0] rx_word,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [31:0] tx_word,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        host_waiting,
    output logic        rx_overrun,
    output logic        tx_timeout,
    input  logic        err_clr
);

    localparam int WAIT_W = (pACK_TIMEOUT < 1) ? 1 : $clog2(pACK_TIMEOUT + 1);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [31:0] gpio_s;
    logic [7:0]  data_s;
    logic [1:0]  in_turn_s;
    logic        out_io_s;
    logic        unused_gpio_hi;

    gpio_sync_bus #(
        .STAGES (pSYNC_STAGES),
        .WIDTH  (32)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (gpio_in),
        .q      (gpio_s)
    );

    assign data_s         = gpio_s[DATA_LSB +: 8];
    assign in_turn_s      = gpio_s[IN_TURN_LSB +: 2];
    assign out_io_s       = gpio_s[OUT_IO_TURN_BIT];
    assign host_waiting   = gpio_s[WAIT_BIT];
    assign unused_gpio_hi = ^gpio_s[31:12];

    rx_state_e   rx_state;
    logic [1:0]  rx_cnt;
    logic [1:0]  in_turn;
    logic [1:0]  rx_turn_lat;
    logic [31:0] rx_buf;

    tx_state_e         tx_state;
    logic [1:0]        tx_cnt;
    logic [1:0]        out_turn;
    logic [31:0]       tx_buf;
    logic [7:0]        data_out;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;

    assign wait_nxt = wait_cnt + WAIT_W'(1);
    assign gpio_out = {20'd0, out_turn, in_turn, data_out};

    // Bytes assemble in rx_buf; rx_word only changes once a full word exists.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_state    <= RX_IDLE;
            rx_cnt      <= '0;
            in_turn     <= '0;
            rx_turn_lat <= '0;
            rx_buf      <= '0;
            rx_word     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            if (err_clr) rx_overrun <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (in_turn_s != in_turn && !rx_valid) rx_state <= RX_CAPTURE;
                end
                RX_CAPTURE: begin
                    rx_buf[{rx_cnt, 3'b000} +: 8] <= data_s;
                    rx_turn_lat <= in_turn_s;
                    if (in_turn_s != turn_next(in_turn)) rx_overrun <= 1'b1;
                    rx_state <= RX_ACK;
                end
                RX_ACK: begin
                    in_turn <= rx_turn_lat;
                    rx_cnt  <= rx_cnt + 2'd1;
                    if (rx_cnt == LAST_BYTE) begin
                        rx_word  <= rx_buf;
                        rx_valid <= 1'b1;
                        rx_state <= RX_HOLD;
                    end else begin
                        rx_state <= RX_IDLE;
                    end
                end
                RX_HOLD: begin
                    if (rx_ready) begin
                        rx_valid <= 1'b0;
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // The IO side acknowledges by mirroring bit 0 of our out turn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            out_turn   <= '0;
            tx_buf     <= '0;
            data_out   <= '0;
            wait_cnt   <= '0;
            tx_ready   <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            if (err_clr) tx_timeout <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        tx_buf   <= tx_word;
                        tx_cnt   <= '0;
                        tx_ready <= 1'b0;
                        tx_state <= TX_SETUP;
                    end
                end
                TX_SETUP: begin
                    data_out <= tx_buf[{tx_cnt, 3'b000} +: 8];
                    tx_state <= TX_ADVANCE;
                end
                TX_ADVANCE: begin
                    out_turn <= turn_next(out_turn);
                    wait_cnt <= '0;
                    tx_state <= TX_WAIT_ACK;
                end
                TX_WAIT_ACK: begin
                    wait_cnt <= wait_nxt;
                    if (out_io_s == out_turn[0]) begin
                        tx_cnt <= tx_cnt + 2'd1;
                        if (tx_cnt == LAST_BYTE) begin
                            tx_ready <= 1'b1;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_state <= TX_SETUP;
                        end
                    end else if (pACK_TIMEOUT != 0 && wait_nxt == WAIT_W'(pACK_TIMEOUT)) begin
                        tx_timeout <= 1'b1;
                        tx_ready   <= 1'b1;
                        tx_state   <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_pulpino_endpoint.sv
// tb/tb_gpio_pulpino_endpoint.sv - directed self-checking bench for gpio_pulpino_endpoint
`timescale 1ns/1ps
module tb_gpio_pulpino_endpoint;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [31:0] rx_word;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] tx_word;
    logic        tx_valid;
    logic        tx_ready;
    logic        host_waiting;
    logic        rx_overrun;
    logic        tx_timeout;
    logic        err_clr;

    logic [7:0]  io_data;
    logic [1:0]  io_turn;
    logic        io_out_turn = 1'b0;
    logic        io_wait;
    logic        echo_en = 1'b0;
    logic [1:0]  prev_turn = 2'd0;
    int          echo_dly = 0;

    logic [7:0]  tx_bytes [$];
    logic [1:0]  tx_turns [$];
    logic [31:0] rx_q [$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign gpio_in = {20'hABCDE, io_wait, io_out_turn, io_turn, io_data};

    gpio_pulpino_endpoint #(
        .pSYNC_STAGES (2),
        .pACK_TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out),
        .rx_word      (rx_word),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_word      (tx_word),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .host_waiting (host_waiting),
        .rx_overrun   (rx_overrun),
        .tx_timeout   (tx_timeout),
        .err_clr      (err_clr)
    );

    // IO-side model: logs each byte the endpoint publishes and echoes the turn bit after a delay.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_turn = 2'd0;
            echo_dly  = 0;
        end else begin
            if (gpio_out[11:10] != prev_turn) begin
                tx_bytes.push_back(gpio_out[7:0]);
                tx_turns.push_back(gpio_out[11:10]);
                prev_turn = gpio_out[11:10];
            end
            if (echo_en && io_out_turn != prev_turn[0]) begin
                echo_dly++;
                if (echo_dly == 3) begin
                    io_out_turn = prev_turn[0];
                    echo_dly    = 0;
                end
            end else begin
                echo_dly = 0;
            end
            if (rx_valid && rx_ready) rx_q.push_back(rx_word);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic offer_byte(input logic [7:0] b, input logic [1:0] t);
        @(negedge clk);
        io_data = b;
        @(negedge clk);
        io_turn = t;
    endtask

    task automatic wait_in_turn(input string tag, input logic [1:0] t);
        int n = 0;
        while (gpio_out[9:8] !== t && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(gpio_out[9:8]), 32'(t));
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input logic [1:0] t);
        offer_byte(b, t);
        wait_in_turn(tag, t);
    endtask

    task automatic wait_rx_valid(input string tag);
        int n = 0;
        while (rx_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(rx_valid), 32'd1);
    endtask

    task automatic pulse_rx_ready(input string tag);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check_eq(tag, 32'(rx_valid), 32'd0);
    endtask

    task automatic tx_send(input string tag, input logic [31:0] w);
        int n = 0;
        tx_word  = w;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(tx_ready), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic tx_wait_done(input string tag);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(tx_ready), 32'd1);
    endtask

    task automatic check_tx_log(input string tag, input logic [31:0] w, input logic [1:0] first_turn);
        check_eq({tag, "_nbytes"}, 32'(tx_bytes.size()), 32'd4);
        for (int i = 0; i < 4 && i < tx_bytes.size(); i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), 32'(tx_bytes[i]), 32'(w[8*i +: 8]));
            check_eq($sformatf("%s_turn%0d", tag, i), 32'(tx_turns[i]), 32'(2'(first_turn + 2'(i))));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        resetn   = 1'b0;
        rx_ready = 1'b0;
        tx_word  = 32'd0;
        tx_valid = 1'b0;
        err_clr  = 1'b0;
        io_data  = 8'd0;
        io_turn  = 2'd0;
        io_wait  = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_gpio_out", gpio_out, 32'd0);
        check_eq("rst_rx_word", rx_word, 32'd0);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_tx_ready", 32'(tx_ready), 32'd0);
        check_eq("rst_flags", 32'({rx_overrun, tx_timeout}), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_tx_ready", 32'(tx_ready), 32'd1);

        // Test 1: reset with two bytes in flight, then a clean word
        send_byte("t1_pre0", 8'hA1, 2'd1);
        send_byte("t1_pre1", 8'hA2, 2'd2);
        @(negedge clk);
        resetn  = 1'b0;
        io_turn = 2'd0;
        io_data = 8'd0;
        repeat (2) @(negedge clk);
        check_eq("t1_rst_gpio_out", gpio_out, 32'd0);
        check_eq("t1_rst_rx_valid", 32'(rx_valid), 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t1_post_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("t1_post_gpio_out", gpio_out, 32'd0);
        send_byte("t1_b0", 8'h11, 2'd1);
        send_byte("t1_b1", 8'h22, 2'd2);
        send_byte("t1_b2", 8'h33, 2'd3);
        send_byte("t1_b3", 8'h44, 2'd0);
        wait_rx_valid("t1_valid");
        check_eq("t1_word", rx_word, 32'h44332211);
        check_eq("t1_overrun", 32'(rx_overrun), 32'd0);
        pulse_rx_ready("t1_drop");

        // Test 2: eight bytes across the 3->0 wrap with the consumer always ready
        rx_q.delete();
        rx_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            send_byte($sformatf("t2_b%0d", i), 8'(8'hA0 + i), 2'(i + 1));
        repeat (6) @(negedge clk);
        rx_ready = 1'b0;
        check_eq("t2_nwords", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            check_eq("t2_word0", rx_q[0], 32'hA3A2A1A0);
            check_eq("t2_word1", rx_q[1], 32'hA7A6A5A4);
        end
        check_eq("t2_overrun", 32'(rx_overrun), 32'd0);

        // Test 3: backpressure holds off the fifth byte
        send_byte("t3_b0", 8'h01, 2'd1);
        send_byte("t3_b1", 8'h02, 2'd2);
        send_byte("t3_b2", 8'h03, 2'd3);
        send_byte("t3_b3", 8'h04, 2'd0);
        wait_rx_valid("t3_valid");
        offer_byte(8'h55, 2'd1);
        repeat (10) @(negedge clk);
        check_eq("t3_turn_held", 32'(gpio_out[9:8]), 32'd0);
        check_eq("t3_valid_held", 32'(rx_valid), 32'd1);
        check_eq("t3_word_held", rx_word, 32'h04030201);
        pulse_rx_ready("t3_drop");
        wait_in_turn("t3_b4", 2'd1);
        send_byte("t3_b5", 8'h66, 2'd2);
        send_byte("t3_b6", 8'h77, 2'd3);
        send_byte("t3_b7", 8'h88, 2'd0);
        wait_rx_valid("t3_valid2");
        check_eq("t3_word2", rx_word, 32'h88776655);
        pulse_rx_ready("t3_drop2");

        // Test 4: serialise one word with a responsive IO side
        tx_bytes.delete();
        tx_turns.delete();
        echo_en = 1'b1;
        tx_send("t4_accept", 32'hDEADBEEF);
        tx_wait_done("t4_done");
        check_tx_log("t4", 32'hDEADBEEF, 2'd1);
        check_eq("t4_data_hold", 32'(gpio_out[7:0]), 32'hDE);
        check_eq("t4_out_turn", 32'(gpio_out[11:10]), 32'd0);
        check_eq("t4_timeout", 32'(tx_timeout), 32'd0);

        // Test 5: IO side never acknowledges
        echo_en = 1'b0;
        tx_send("t5_accept", 32'h12345678);
        n = 0;
        while (gpio_out[11:10] !== 2'd1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("t5_turn", 32'(gpio_out[11:10]), 32'd1);
        check_eq("t5_data", 32'(gpio_out[7:0]), 32'h78);
        repeat (7) @(negedge clk);
        check_eq("t5_not_yet", 32'(tx_timeout), 32'd0);
        @(negedge clk);
        check_eq("t5_timeout", 32'(tx_timeout), 32'd1);
        check_eq("t5_tx_ready", 32'(tx_ready), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("t5_clr", 32'(tx_timeout), 32'd0);
        echo_en = 1'b1;
        repeat (8) @(negedge clk);

        // Test 6: turn jump flags overrun while a TX word runs alongside
        tx_bytes.delete();
        tx_turns.delete();
        fork
            begin
                tx_send("t6_accept", 32'hCAFEF00D);
                tx_wait_done("t6_tx_done");
            end
            begin
                send_byte("t6_b0", 8'h5A, 2'd2);
                check_eq("t6_overrun", 32'(rx_overrun), 32'd1);
                send_byte("t6_b1", 8'h6B, 2'd3);
                send_byte("t6_b2", 8'h7C, 2'd0);
                send_byte("t6_b3", 8'h8D, 2'd1);
                wait_rx_valid("t6_valid");
            end
        join
        check_eq("t6_word", rx_word, 32'h8D7C6B5A);
        check_tx_log("t6", 32'hCAFEF00D, 2'd2);
        check_eq("t6_timeout", 32'(tx_timeout), 32'd0);
        pulse_rx_ready("t6_drop");
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("t6_clr", 32'(rx_overrun), 32'd0);

        io_wait = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("host_waiting", 32'(host_waiting), 32'd1);
        check_eq("gpio_out_hi_zero", 32'(gpio_out[31:12]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
